mini_clause_loader: RTL and testbench



---
 rtl/mini_pkg.sv | 27 ++
 rtl/mini_lit_dedup.sv | 34 +++
 rtl/mini_clause_loader.sv | 150 +++++++++++++++
 tb/tb_mini_clause_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_pkg.sv
// mini_pkg: shared types, constants and literal encoding for the Mini DPLL front end
package mini_pkg;
    localparam int DEF_MAX_CLAUSE_LEN = 16;
    localparam int LEN_W = $clog2(DEF_MAX_CLAUSE_LEN + 1);

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_VAR   = 3'd1,
        ERR_LONG  = 3'd2,
        ERR_LITS  = 3'd3,
        ERR_CLS   = 3'd4,
        ERR_EMPTY = 3'd5,
        ERR_FMT   = 3'd6
    } loader_err_t;

    typedef enum logic [2:0] {L_IDLE, L_RECV, L_COMMIT, L_DONE, L_ERROR} loader_state_t;

    function automatic logic [31:0] lit_abs(input logic signed [31:0] lit);
        return lit[31] ? -lit : lit;
    endfunction

    function automatic logic [31:0] lit_encode(input logic signed [31:0] lit);
        logic [31:0] v;
        v = lit_abs(lit);
        return {v[30:0], lit[31]};
    endfunction
endpackage

// File: rtl/mini_lit_dedup.sv
// mini_lit_dedup: clause-local CAM of encoded literals reporting same and complementary hits
module mini_lit_dedup #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [31:0]      wr_data,
    input  logic [31:0]      probe,
    output logic             hit_same,
    output logic             hit_comp
);
    logic [31:0] buffer [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) if (wr_en && cnt == CNT_W'(i)) buffer[i] <= wr_data;
        end
    end

    // only the first cnt entries belong to the clause being received
    always_comb begin
        hit_same = 1'b0;
        hit_comp = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_same = hit_same | (CNT_W'(i) < cnt && buffer[i] == probe);
            hit_comp = hit_comp | (CNT_W'(i) < cnt && buffer[i] == (probe ^ 32'd1));
        end
    end
endmodule

// File: rtl/mini_clause_loader.sv
// mini_clause_loader: DIMACS literal stream to literal memory and clause table.
// Define MINI_LOADER_DEDUP_EN to drop duplicate literals and tautological clauses.
module mini_clause_loader
    import mini_pkg::*;
#(
    parameter int MAX_VARS       = 256,
    parameter int MAX_CLAUSES    = 256,
    parameter int MAX_LITS       = 2048,
    parameter int MAX_CLAUSE_LEN = 16,
    parameter int PTR_W          = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                lit_valid,
    output logic                                lit_ready,
    input  logic [31:0]                         lit_data,
    input  logic                                lit_last,
    output logic                                lit_wr_en,
    output logic [PTR_W-1:0]                    lit_wr_addr,
    output logic [31:0]                         lit_wr_data,
    output logic                                cls_wr_en,
    output logic [$clog2(MAX_CLAUSES)-1:0]      cls_wr_idx,
    output logic [PTR_W-1:0]                    cls_wr_start,
    output logic [$clog2(MAX_CLAUSE_LEN+1)-1:0] cls_wr_len,
    output logic                                done,
    output logic                                error,
    output logic [2:0]                          err_code,
    output logic [PTR_W-1:0]                    num_clauses,
    output logic [PTR_W-1:0]                    num_lits,
    output logic [31:0]                         max_var
);
    localparam int IDX_W  = $clog2(MAX_CLAUSES);
    localparam int CLEN_W = $clog2(MAX_CLAUSE_LEN + 1);

    loader_state_t state, state_nxt;
    loader_err_t   beat_err;
    logic [CLEN_W-1:0] cur_len;
    logic [PTR_W-1:0]  clause_base;
    logic [31:0]       lit_var, lit_enc;
    logic last_pend, taut, accept, is_zero, hit_same, hit_comp;

    // start takes priority so a beat offered alongside it is never half-consumed
    assign lit_ready = state == L_RECV && !start;
    assign accept    = lit_valid && lit_ready;
    assign is_zero   = lit_data == 32'd0;
    assign lit_var   = lit_abs(lit_data);
    assign lit_enc   = lit_encode(lit_data);

`ifdef MINI_LOADER_DEDUP_EN
    mini_lit_dedup #(.DEPTH(MAX_CLAUSE_LEN), .CNT_W(CLEN_W)) u_dedup (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(accept && beat_err == ERR_NONE && !is_zero && !hit_same),
        .cnt(cur_len),
        .wr_data(lit_enc),
        .probe(lit_enc),
        .hit_same(hit_same),
        .hit_comp(hit_comp)
    );
`else
    assign hit_same = 1'b0;
    assign hit_comp = 1'b0;
`endif

    // a duplicate needs no storage, so it bypasses the capacity checks
    always_comb
        beat_err = (lit_last && !is_zero) ? ERR_FMT :
                   is_zero ? (cur_len == '0 ? ERR_EMPTY :
                              num_clauses == PTR_W'(MAX_CLAUSES) ? ERR_CLS : ERR_NONE) :
                   lit_var >= 32'(MAX_VARS) ? ERR_VAR :
                   hit_same ? ERR_NONE :
                   cur_len == CLEN_W'(MAX_CLAUSE_LEN) ? ERR_LONG :
                   num_lits == PTR_W'(MAX_LITS) ? ERR_LITS : ERR_NONE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= L_IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            L_RECV:   state_nxt = !accept ? L_RECV : beat_err != ERR_NONE ? L_ERROR : is_zero ? L_COMMIT : L_RECV;
            L_COMMIT: state_nxt = last_pend ? L_DONE : L_RECV;
            default:  state_nxt = state;
        endcase
        if (start) state_nxt = L_RECV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lit_wr_en    <= 1'b0;
            lit_wr_addr  <= '0;
            lit_wr_data  <= '0;
            cls_wr_en    <= 1'b0;
            cls_wr_idx   <= '0;
            cls_wr_start <= '0;
            cls_wr_len   <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 3'd0;
            num_clauses  <= '0;
            num_lits     <= '0;
            max_var      <= '0;
            cur_len      <= '0;
            clause_base  <= '0;
            last_pend    <= 1'b0;
            taut         <= 1'b0;
        end else begin
            lit_wr_en <= 1'b0;
            cls_wr_en <= 1'b0;
            if (start) begin
                done        <= 1'b0;
                error       <= 1'b0;
                err_code    <= 3'd0;
                num_clauses <= '0;
                num_lits    <= '0;
                max_var     <= '0;
                cur_len     <= '0;
                clause_base <= '0;
                last_pend   <= 1'b0;
                taut        <= 1'b0;
            end else if (accept && beat_err != ERR_NONE) begin
                error    <= 1'b1;
                err_code <= beat_err;
            end else if (accept && is_zero) begin
                cls_wr_en    <= !taut;
                cls_wr_idx   <= num_clauses[IDX_W-1:0];
                cls_wr_start <= clause_base;
                cls_wr_len   <= cur_len;
                num_clauses  <= num_clauses + PTR_W'(!taut);
                num_lits     <= taut ? clause_base : num_lits;
                clause_base  <= taut ? clause_base : num_lits;
                cur_len      <= '0;
                taut         <= 1'b0;
                last_pend    <= lit_last;
            end else if (accept && !hit_same) begin
                lit_wr_en   <= 1'b1;
                lit_wr_addr <= num_lits;
                lit_wr_data <= lit_enc;
                num_lits    <= num_lits + PTR_W'(1);
                cur_len     <= cur_len + CLEN_W'(1);
                max_var     <= lit_var > max_var ? lit_var : max_var;
                taut        <= taut | hit_comp;
            end else if (state == L_COMMIT && last_pend) begin
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mini_clause_loader.sv
// tb_mini_clause_loader: directed table and sequence checks for mini_clause_loader
module tb_mini_clause_loader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, lit_valid = 1'b0, lit_last = 1'b0;
    logic [31:0] lit_data = '0;
    logic        lit_ready, lit_wr_en, cls_wr_en, done, error;
    logic [15:0] lit_wr_addr, cls_wr_start, num_clauses, num_lits;
    logic [31:0] lit_wr_data, max_var;
    logic [7:0]  cls_wr_idx;
    logic [4:0]  cls_wr_len;
    logic [2:0]  err_code;

    int checks = 0, errors = 0;
    int wa[$], wd[$], ci[$], cs[$], cl[$];

    typedef struct {
        int v, d, last, rdy, we, wa, wd, ce, ci, cs, cl, dn;
    } vec_t;
    vec_t tv[7];

    always #5 clk = ~clk;

    mini_clause_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lit_valid(lit_valid), .lit_ready(lit_ready), .lit_data(lit_data), .lit_last(lit_last),
        .lit_wr_en(lit_wr_en), .lit_wr_addr(lit_wr_addr), .lit_wr_data(lit_wr_data),
        .cls_wr_en(cls_wr_en), .cls_wr_idx(cls_wr_idx), .cls_wr_start(cls_wr_start), .cls_wr_len(cls_wr_len),
        .done(done), .error(error), .err_code(err_code),
        .num_clauses(num_clauses), .num_lits(num_lits), .max_var(max_var)
    );

    always @(negedge clk) begin
        if (rst_n && lit_wr_en) begin
            wa.push_back(int'(lit_wr_addr));
            wd.push_back(int'(lit_wr_data));
        end
        if (rst_n && cls_wr_en) begin
            ci.push_back(int'(cls_wr_idx));
            cs.push_back(int'(cls_wr_start));
            cl.push_back(int'(cls_wr_len));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic beat(input int d, input bit last);
        bit took = 1'b0;
        lit_valid = 1'b1;
        lit_data  = d;
        lit_last  = last;
        for (int n = 0; n < 40 && !took; n++) begin
            #1;
            took = lit_ready;
            @(posedge clk);
            #1;
        end
        lit_valid = 1'b0;
        lit_last  = 1'b0;
        lit_data  = '0;
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: literal %0d not accepted within 40 cycles", d);
        end
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 20 && !done; n++) idle(1);
        chk(name, int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, c;
        tv[0] = '{1,  1, 0, 1, 1, 0, 2, 0, 0, 0, 0, 0};
        tv[1] = '{1, -2, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0};
        tv[2] = '{1,  0, 0, 1, 0, 0, 0, 1, 0, 0, 2, 0};
        tv[3] = '{1,  3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[4] = '{1,  3, 0, 1, 1, 2, 6, 0, 0, 0, 0, 0};
        tv[5] = '{1,  0, 1, 1, 0, 0, 0, 1, 1, 2, 1, 0};
        tv[6] = '{0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        idle(2);
        chk("rst lit_ready", int'(lit_ready), 0);
        chk("rst lit_wr_en", int'(lit_wr_en), 0);
        chk("rst cls_wr_en", int'(cls_wr_en), 0);
        chk("rst done", int'(done), 0);
        chk("rst error", int'(error), 0);
        chk("rst err_code", int'(err_code), 0);
        chk("rst num_clauses", int'(num_clauses), 0);
        chk("rst num_lits", int'(num_lits), 0);
        chk("rst max_var", int'(max_var), 0);
        rst_n = 1'b1;
        idle(1);
        chk("idle lit_ready", int'(lit_ready), 0);

        do_start();
        for (int i = 0; i < 7; i++) begin
            lit_valid = tv[i].v != 0;
            lit_data  = tv[i].d;
            lit_last  = tv[i].last != 0;
            #1;
            chk($sformatf("t1[%0d] lit_ready", i), int'(lit_ready), tv[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("t1[%0d] lit_wr_en", i), int'(lit_wr_en), tv[i].we);
            if (tv[i].we != 0) begin
                chk($sformatf("t1[%0d] lit_wr_addr", i), int'(lit_wr_addr), tv[i].wa);
                chk($sformatf("t1[%0d] lit_wr_data", i), int'(lit_wr_data), tv[i].wd);
            end
            chk($sformatf("t1[%0d] cls_wr_en", i), int'(cls_wr_en), tv[i].ce);
            if (tv[i].ce != 0) begin
                chk($sformatf("t1[%0d] cls_wr_idx", i), int'(cls_wr_idx), tv[i].ci);
                chk($sformatf("t1[%0d] cls_wr_start", i), int'(cls_wr_start), tv[i].cs);
                chk($sformatf("t1[%0d] cls_wr_len", i), int'(cls_wr_len), tv[i].cl);
            end
            chk($sformatf("t1[%0d] done", i), int'(done), tv[i].dn);
        end
        lit_valid = 1'b0;
        lit_last  = 1'b0;
        chk("t1 num_clauses", int'(num_clauses), 2);
        chk("t1 num_lits", int'(num_lits), 3);
        chk("t1 max_var", int'(max_var), 3);
        chk("t1 error", int'(error), 0);

        do_start();
        chk("t2 done cleared", int'(done), 0);
        b = wa.size();
        beat(256, 1'b0);
        chk("t2 error", int'(error), 1);
        chk("t2 err_code", int'(err_code), 1);
        chk("t2 lit_wr_en", int'(lit_wr_en), 0);
        lit_valid = 1'b1;
        #1;
        chk("t2 lit_ready", int'(lit_ready), 0);
        lit_valid = 1'b0;
        idle(2);
        chk("t2 writes", wa.size() - b, 0);

        do_start();
        chk("t3 error cleared", int'(error), 0);
        chk("t3 err_code cleared", int'(err_code), 0);
        b = wa.size();
        for (int k = 1; k <= 17; k++) beat(k, 1'b0);
        idle(1);
        chk("t3 writes", wa.size() - b, 16);
        chk("t3 err_code", int'(err_code), 2);
        if (wa.size() - b == 16) begin
            chk("t3 last addr", wa[b + 15], 15);
            chk("t3 last data", wd[b + 15], 32);
        end

        do_start();
        beat(0, 1'b0);
        chk("t4 empty err_code", int'(err_code), 5);
        do_start();
        b = wa.size();
        beat(4, 1'b1);
        idle(1);
        chk("t4 fmt err_code", int'(err_code), 6);
        chk("t4 fmt writes", wa.size() - b, 0);

        do_start();
        idle($urandom_range(0, 2));
        beat(1, 1'b0);
        idle($urandom_range(0, 2));
        beat(-2, 1'b0);
        idle(1);
        do_start();
        chk("t5 restart num_lits", int'(num_lits), 0);
        chk("t5 restart lit_wr_en", int'(lit_wr_en), 0);
        b = wa.size();
        c = ci.size();
        idle($urandom_range(0, 3)); beat(1, 1'b0);
        idle($urandom_range(0, 3)); beat(-2, 1'b0);
        idle($urandom_range(0, 3)); beat(0, 1'b0);
        idle($urandom_range(0, 3)); beat(3, 1'b0);
        idle($urandom_range(0, 3)); beat(0, 1'b1);
        wait_done("t5 done");
        chk("t5 lit writes", wa.size() - b, 3);
        chk("t5 cls writes", ci.size() - c, 2);
        if (wa.size() - b == 3) begin
            chk("t5 w0 addr", wa[b], 0);
            chk("t5 w0 data", wd[b], 2);
            chk("t5 w1 addr", wa[b + 1], 1);
            chk("t5 w1 data", wd[b + 1], 5);
            chk("t5 w2 addr", wa[b + 2], 2);
            chk("t5 w2 data", wd[b + 2], 6);
        end
        if (ci.size() - c == 2) begin
            chk("t5 c0 idx", ci[c], 0);
            chk("t5 c0 start", cs[c], 0);
            chk("t5 c0 len", cl[c], 2);
            chk("t5 c1 idx", ci[c + 1], 1);
            chk("t5 c1 start", cs[c + 1], 2);
            chk("t5 c1 len", cl[c + 1], 1);
        end
        chk("t5 num_clauses", int'(num_clauses), 2);
        chk("t5 num_lits", int'(num_lits), 3);
        chk("t5 max_var", int'(max_var), 3);

`ifdef MINI_LOADER_DEDUP_EN
        do_start();
        b = wa.size();
        c = ci.size();
        beat(1, 1'b0);
        beat(1, 1'b0);
        beat(-2, 1'b0);
        beat(0, 1'b0);
        beat(1, 1'b0);
        beat(-1, 1'b0);
        beat(0, 1'b1);
        wait_done("t6 done");
        chk("t6 cls writes", ci.size() - c, 1);
        if (ci.size() - c == 1) chk("t6 cls len", cl[c], 2);
        chk("t6 lit writes", wa.size() - b, 4);
        chk("t6 num_clauses", int'(num_clauses), 1);
        chk("t6 num_lits", int'(num_lits), 2);
`endif

        do_start();
        beat(5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t7 reset lit_ready", int'(lit_ready), 0);
        chk("t7 reset num_lits", int'(num_lits), 0);
        chk("t7 reset max_var", int'(max_var), 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        chk("t7 idle after reset", int'(lit_ready), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
